// File: rtl/mul_pipe.sv
// mul_pipe: three-stage pipelined WIDTH x WIDTH multiplier returning MUL / MULH / MULHU words,
// with valid/ready handshake, flush and a pass-through tag. Define MUL_STALL_CNT_EN for stall_cnt.
module mul_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [TAG_W-1:0] out_tag
`ifdef MUL_STALL_CNT_EN
  ,
  output logic [31:0]      stall_cnt
`endif
);

  localparam int unsigned HALF = WIDTH / 2;
  localparam int unsigned PW   = 2 * HALF;
  localparam int unsigned DW   = 2 * WIDTH;

  localparam logic [1:0] OP_MULH  = 2'b01;
  localparam logic [1:0] OP_MULHU = 2'b10;

  // Stage valid bits
  logic v0_q, v0_d;
  logic v1_q, v1_d;
  logic v2_q, v2_d;

  // S0: operand magnitudes, sign and word select
  logic [WIDTH-1:0] a0_q, a0_d;
  logic [WIDTH-1:0] b0_q, b0_d;
  logic             sgn0_q, sgn0_d;
  logic             hi0_q, hi0_d;
  logic [TAG_W-1:0] tag0_q, tag0_d;

  // S1: partial products
  logic [PW-1:0]    p00_q, p00_d;
  logic [PW-1:0]    p01_q, p01_d;
  logic [PW-1:0]    p10_q, p10_d;
  logic [PW-1:0]    p11_q, p11_d;
  logic             sgn1_q, sgn1_d;
  logic             hi1_q, hi1_d;
  logic [TAG_W-1:0] tag1_q, tag1_d;

  // S2: registered result
  logic [WIDTH-1:0] out_res_q, out_res_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;

  logic adv0_c, adv1_c, adv2_c;

  logic             op_signed_c;
  logic             a_neg_c, b_neg_c;
  logic             sgn_c, hi_c;
  logic [WIDTH-1:0] a_mag_c, b_mag_c;

  logic [HALF-1:0]  a_lo_c, a_hi_c, b_lo_c, b_hi_c;
  logic [PW-1:0]    p00_c, p01_c, p10_c, p11_c;

  logic [DW-1:0]    sum_c, prod_c;
  logic [WIDTH-1:0] res_c;

  // A stage may move when the one below it is empty or moving
  always_comb begin
    adv2_c = out_ready | ~v2_q;
    adv1_c = adv2_c | ~v1_q;
    adv0_c = adv1_c | ~v0_q;
  end

  assign in_ready  = adv0_c;
  assign out_valid = v2_q;
  assign out_res   = out_res_q;
  assign out_tag   = out_tag_q;

  // Sign handling only for MULH; the most negative value keeps its pattern as unsigned 2^(W-1)
  always_comb begin
    op_signed_c = (in_op == OP_MULH);
    hi_c        = (in_op == OP_MULH) | (in_op == OP_MULHU);
    a_neg_c     = op_signed_c & in_a[WIDTH-1];
    b_neg_c     = op_signed_c & in_b[WIDTH-1];
    sgn_c       = a_neg_c ^ b_neg_c;
    a_mag_c     = a_neg_c ? (~in_a + WIDTH'(1)) : in_a;
    b_mag_c     = b_neg_c ? (~in_b + WIDTH'(1)) : in_b;
  end

  always_comb begin
    a_lo_c = a0_q[HALF-1:0];
    a_hi_c = a0_q[WIDTH-1:HALF];
    b_lo_c = b0_q[HALF-1:0];
    b_hi_c = b0_q[WIDTH-1:HALF];
    p00_c  = PW'(a_lo_c) * PW'(b_lo_c);
    p01_c  = PW'(a_lo_c) * PW'(b_hi_c);
    p10_c  = PW'(a_hi_c) * PW'(b_lo_c);
    p11_c  = PW'(a_hi_c) * PW'(b_hi_c);
  end

  // Recombine the partial products, then restore the sign
  always_comb begin
    sum_c  = DW'(p00_q)
           + (DW'(p01_q) << HALF)
           + (DW'(p10_q) << HALF)
           + (DW'(p11_q) << WIDTH);
    prod_c = sgn1_q ? (~sum_c + DW'(1)) : sum_c;
    res_c  = hi1_q ? prod_c[DW-1:WIDTH] : prod_c[WIDTH-1:0];
  end

  always_comb begin
    v0_d      = v0_q;
    v1_d      = v1_q;
    v2_d      = v2_q;
    a0_d      = a0_q;
    b0_d      = b0_q;
    sgn0_d    = sgn0_q;
    hi0_d     = hi0_q;
    tag0_d    = tag0_q;
    p00_d     = p00_q;
    p01_d     = p01_q;
    p10_d     = p10_q;
    p11_d     = p11_q;
    sgn1_d    = sgn1_q;
    hi1_d     = hi1_q;
    tag1_d    = tag1_q;
    out_res_d = out_res_q;
    out_tag_d = out_tag_q;

    if (flush) begin
      v0_d = 1'b0;
      v1_d = 1'b0;
      v2_d = 1'b0;
    end else begin
      if (adv2_c) v2_d = v1_q;
      if (adv1_c) v1_d = v0_q;
      if (adv0_c) v0_d = in_valid;

      if (adv0_c && in_valid) begin
        a0_d   = a_mag_c;
        b0_d   = b_mag_c;
        sgn0_d = sgn_c;
        hi0_d  = hi_c;
        tag0_d = in_tag;
      end

      if (adv1_c && v0_q) begin
        p00_d  = p00_c;
        p01_d  = p01_c;
        p10_d  = p10_c;
        p11_d  = p11_c;
        sgn1_d = sgn0_q;
        hi1_d  = hi0_q;
        tag1_d = tag0_q;
      end

      // Output word only changes when a new result enters S2, so it holds under back-pressure
      if (adv2_c && v1_q) begin
        out_res_d = res_c;
        out_tag_d = tag1_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v0_q      <= 1'b0;
      v1_q      <= 1'b0;
      v2_q      <= 1'b0;
      a0_q      <= '0;
      b0_q      <= '0;
      sgn0_q    <= 1'b0;
      hi0_q     <= 1'b0;
      tag0_q    <= '0;
      p00_q     <= '0;
      p01_q     <= '0;
      p10_q     <= '0;
      p11_q     <= '0;
      sgn1_q    <= 1'b0;
      hi1_q     <= 1'b0;
      tag1_q    <= '0;
      out_res_q <= '0;
      out_tag_q <= '0;
    end else begin
      v0_q      <= v0_d;
      v1_q      <= v1_d;
      v2_q      <= v2_d;
      a0_q      <= a0_d;
      b0_q      <= b0_d;
      sgn0_q    <= sgn0_d;
      hi0_q     <= hi0_d;
      tag0_q    <= tag0_d;
      p00_q     <= p00_d;
      p01_q     <= p01_d;
      p10_q     <= p10_d;
      p11_q     <= p11_d;
      sgn1_q    <= sgn1_d;
      hi1_q     <= hi1_d;
      tag1_q    <= tag1_d;
      out_res_q <= out_res_d;
      out_tag_q <= out_tag_d;
    end
  end

`ifdef MUL_STALL_CNT_EN
  // Cycles a valid result is held by the consumer; survives flush
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (v2_q && !out_ready) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mul_pipe.sv
// tb_mul_pipe: directed bench for mul_pipe with a queue-based reference model checked every cycle.
// Define MUL_STALL_CNT_EN to also check the stall counter.
module tb_mul_pipe;

  localparam int unsigned W  = 32;
  localparam int unsigned TW = 5;

  logic          clk = 1'b0;
  logic          rstn;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_op;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_res;
  logic [TW-1:0] out_tag;
`ifdef MUL_STALL_CNT_EN
  logic [31:0]   stall_cnt;
`endif

  int n_run  = 0;
  int n_fail = 0;

  logic [W-1:0]  exp_res_q[$];
  logic [TW-1:0] exp_tag_q[$];
  int unsigned   stall_m = 0;

  mul_pipe #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .flush    (flush),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_op    (in_op),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_tag   (in_tag),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_res  (out_res),
    .out_tag  (out_tag)
`ifdef MUL_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_run++;
    n_fail++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  // Reference: full-width product by plain arithmetic, then pick the word
  function automatic logic [W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    longint        sa, sb;
    logic [63:0]   p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'b01:   begin p = 64'(sa * sb);             return p[63:32]; end
      2'b10:   begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      default: begin p = {32'd0, a} * {32'd0, b}; return p[31:0];  end
    endcase
  endfunction

  // Per-cycle scoreboard step, sampled mid-cycle
  task automatic mon_step();
    if (!rstn) begin
      exp_res_q.delete();
      exp_tag_q.delete();
      stall_m = 0;
      chk("mon_reset_valid", 64'(out_valid), 64'd0);
    end else begin
`ifdef MUL_STALL_CNT_EN
      chk("mon_stall_cnt", 64'(stall_cnt), 64'(stall_m));
      if (out_valid && !out_ready) stall_m++;
`endif
      if (out_valid) begin
        if (exp_res_q.size() == 0) begin
          fail_now("mon_spurious_out");
        end else begin
          chk("mon_res", 64'(out_res), 64'(exp_res_q[0]));
          chk("mon_tag", 64'(out_tag), 64'(exp_tag_q[0]));
          if (out_ready) begin
            void'(exp_res_q.pop_front());
            void'(exp_tag_q.pop_front());
          end
        end
      end
      if (flush) begin
        exp_res_q.delete();
        exp_tag_q.delete();
      end else if (in_valid && in_ready) begin
        exp_res_q.push_back(model(in_op, in_a, in_b));
        exp_tag_q.push_back(in_tag);
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_tag   = tag;
  endtask

  task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag);
    bit acc;
    acc = 1'b0;
    drive(op, a, b, tag);
    for (int i = 0; i < 20 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      step();
    end
    in_valid = 1'b0;
    if (!acc) fail_now("issue_timeout");
  endtask

  // Issue into an empty pipe and pin the exact three-cycle latency
  task automatic issue_lat(input string name, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input logic [TW-1:0] tag,
                           input logic [W-1:0] exp_res);
    issue(op, a, b, tag);
    chk({name, "_c1_valid"}, 64'(out_valid), 64'd0);
    step();
    chk({name, "_c2_valid"}, 64'(out_valid), 64'd0);
    step();
    chk({name, "_c3_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_res"}, 64'(out_res), 64'(exp_res));
    chk({name, "_tag"}, 64'(out_tag), 64'(tag));
    step();
  endtask

  task automatic wait_out(input string name, input logic [W-1:0] exp_res,
                          input logic [TW-1:0] exp_tag);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (out_valid) begin
        found = 1'b1;
        chk({name, "_res"}, 64'(out_res), 64'(exp_res));
        chk({name, "_tag"}, 64'(out_tag), 64'(exp_tag));
      end
    end
    if (!found) fail_now({name, "_timeout"});
    step();
  endtask

  initial begin
    int          n_acc, n_got;
    logic [W-1:0] got_res [5];
    int          got_cyc [5];
    int          exp_sq  [5];
    logic [W-1:0] first_res;
`ifdef MUL_STALL_CNT_EN
    logic [31:0] stall_base;
`endif
    exp_sq = '{1, 4, 9, 16, 25};

    rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 2'b00;
    in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;

    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    #1;
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_res", 64'(out_res), 64'd0);
    chk("reset_out_tag", 64'(out_tag), 64'd0);
`ifdef MUL_STALL_CNT_EN
    chk("reset_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    chk("reset_in_ready", 64'(in_ready), 64'd1);

    // Basic ops
    issue_lat("mul_lat", 2'b00, 32'h0000_0007, 32'hFFFF_FFFD, 5'd3, 32'hFFFF_FFEB);
    issue(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd4);
    wait_out("mulh_minmin", 32'h4000_0000, 5'd4);
    issue(2'b01, 32'hFFFF_FFFF, 32'h0000_0001, 5'd5);
    wait_out("mulh_neg1", 32'hFFFF_FFFF, 5'd5);
    issue(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6);
    wait_out("mulhu_max", 32'hFFFF_FFFE, 5'd6);
    issue(2'b11, 32'h0000_0003, 32'h0000_0005, 5'd7);
    wait_out("op11_as_mul", 32'h0000_000F, 5'd7);

    // Back-pressure: five back-to-back ops, consumer stalled for six cycles
`ifdef MUL_STALL_CNT_EN
    stall_base = stall_cnt;
`endif
    n_acc = 0;
    n_got = 0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      out_ready = (cyc >= 6);
      if (n_acc < 5) drive(2'b00, W'(n_acc + 1), W'(n_acc + 1), TW'(n_acc + 1));
      else           in_valid = 1'b0;
      @(negedge clk);
      if (cyc == 3) chk("bp_in_ready_drop", 64'(in_ready), 64'd0);
      if (in_valid && in_ready) n_acc++;
      if (out_valid && out_ready && n_got < 5) begin
        got_res[n_got] = out_res;
        got_cyc[n_got] = cyc;
        n_got++;
      end
      if (cyc == 5) chk("bp_accepts_while_held", 64'(n_acc), 64'd3);
      step();
    end
    in_valid = 1'b0;
    chk("bp_result_count", 64'(n_got), 64'd5);
    for (int k = 0; k < 5; k++) begin
      if (k < n_got) begin
        chk("bp_result", 64'(got_res[k]), 64'(exp_sq[k]));
        chk("bp_result_cycle", 64'(got_cyc[k]), 64'(6 + k));
      end
    end
`ifdef MUL_STALL_CNT_EN
    chk("bp_stall_cnt", 64'(stall_cnt - stall_base), 64'd3);
`endif

    // Flush with all three stages full and the consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(2'b00, W'(10 + i), 32'd1, TW'(10 + i));
      step();
    end
    chk("flush_full_valid", 64'(out_valid), 64'd1);
    chk("flush_full_in_ready", 64'(in_ready), 64'd0);
    flush = 1'b1;
    drive(2'b00, 32'd99, 32'd1, 5'd31);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_cleared_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    issue_lat("post_flush", 2'b00, 32'd6, 32'd7, 5'd9, 32'd42);
    for (int i = 0; i < 4; i++) begin
      chk("post_flush_no_stale", 64'(out_valid), 64'd0);
      step();
    end

    // Flush while S2 is being consumed: that result leaves once, the rest are dropped
    n_got = 0;
    first_res = '0;
    for (int cyc = 0; cyc < 9; cyc++) begin
      if (cyc < 4) drive(2'b00, W'(cyc + 2), 32'd3, TW'(cyc + 1));
      else         in_valid = 1'b0;
      flush = (cyc == 3);
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (n_got == 0) first_res = out_res;
        n_got++;
      end
      step();
    end
    flush = 1'b0;
    chk("flush_consume_count", 64'(n_got), 64'd1);
    chk("flush_consume_res", 64'(first_res), 64'd6);

    // Asynchronous reset with two operations in flight
    for (int i = 0; i < 2; i++) begin
      drive(2'b00, W'(20 + i), 32'd2, TW'(20 + i));
      step();
    end
    in_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("async_rst_valid", 64'(out_valid), 64'd0);
    chk("async_rst_res", 64'(out_res), 64'd0);
    chk("async_rst_tag", 64'(out_tag), 64'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("post_rst_no_result", 64'(out_valid), 64'd0);
      step();
    end
    issue_lat("post_rst", 2'b10, 32'h0001_0000, 32'h0001_0000, 5'd2, 32'h0000_0001);

    repeat (4) step();
    chk("queue_drained", 64'(exp_res_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
